// File: rtl/pixel_stream_packer.sv
// Packs a raster-order pixel stream into 3-lane beats (short final beat zero-padded) for the image core.
// Latency: a beat is presented the cycle after its last lane is filled; input stalls while a beat waits on out_ready.
module pixel_stream_packer #(
    parameter int IMG_DIM    = 20,
    parameter int BIT_LENGTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIT_LENGTH-1:0] in_pixel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIT_LENGTH-1:0] out_pix0,
    output logic [BIT_LENGTH-1:0] out_pix1,
    output logic [BIT_LENGTH-1:0] out_pix2,
    output logic [1:0]            out_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  load_end,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int TOTAL = IMG_DIM * IMG_DIM;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state;
    logic [1:0]            lane_idx;
    logic [CW-1:0]         pix_cnt;
    logic [BIT_LENGTH-1:0] lane0;
    logic [BIT_LENGTH-1:0] lane1;
    logic [BIT_LENGTH-1:0] lane2;
    logic [1:0]            beat_count;
    logic                  beat_last;
    logic                  accept;
    logic                  last_pix;
    logic                  beat_full;

    assign accept    = (state == FILL) && in_valid;
    assign last_pix  = (pix_cnt == LAST_IDX);
    assign beat_full = (lane_idx == 2'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lane_idx   <= 2'd0;
            pix_cnt    <= '0;
            lane0      <= '0;
            lane1      <= '0;
            lane2      <= '0;
            beat_count <= 2'd0;
            beat_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pix_cnt    <= '0;
                        lane_idx   <= 2'd0;
                        lane0      <= '0;
                        lane1      <= '0;
                        lane2      <= '0;
                        beat_count <= 2'd0;
                        beat_last  <= 1'b0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        case (lane_idx)
                            2'd0:    lane0 <= in_pixel;
                            2'd1:    lane1 <= in_pixel;
                            default: lane2 <= in_pixel;
                        endcase
                        lane_idx <= lane_idx + 2'd1;
                        pix_cnt  <= pix_cnt + CW'(1);
                        // The frame's last pixel closes the beat early; unfilled lanes stay zero.
                        if (beat_full || last_pix) begin
                            beat_count <= lane_idx + 2'd1;
                            beat_last  <= last_pix;
                            state      <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        lane_idx   <= 2'd0;
                        lane0      <= '0;
                        lane1      <= '0;
                        lane2      <= '0;
                        beat_count <= 2'd0;
                        beat_last  <= 1'b0;
                        state      <= beat_last ? DONE : FILL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == FILL);
    assign out_valid  = (state == SEND);
    assign out_pix0   = out_valid ? lane0 : '0;
    assign out_pix1   = out_valid ? lane1 : '0;
    assign out_pix2   = out_valid ? lane2 : '0;
    assign out_count  = beat_count;
    assign load_end   = beat_last;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer: scoreboard of expected beats built from accepted pixels,
// plus a spot-check table and hand-written stall / toggle / mid-frame start / reset sequences.
module tb_pixel_stream_packer;
    localparam int IMG    = 20;
    localparam int TOTAL  = IMG * IMG;
    localparam int NBEATS = (TOTAL + 2) / 3;

    typedef struct packed {
        logic [4:0] p0;
        logic [4:0] p1;
        logic [4:0] p2;
        logic [1:0] cnt;
        logic       le;
    } beat_t;

    typedef struct {
        int beat;
        int p0;
        int p1;
        int p2;
        int cnt;
        int le;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic [4:0] in_pixel;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] out_pix0, out_pix1, out_pix2;
    logic [1:0] out_count;
    logic       out_valid;
    logic       out_ready;
    logic       load_end;
    logic       busy;
    logic       frame_done;

    logic       s3_start;
    logic [4:0] s3_pixel;
    logic       s3_valid;
    logic       s3_in_ready;
    logic [4:0] s3_p0, s3_p1, s3_p2;
    logic [1:0] s3_count;
    logic       s3_out_valid;
    logic       s3_out_ready;
    logic       s3_load_end;
    logic       s3_busy;
    logic       s3_frame_done;

    pixel_stream_packer #(.IMG_DIM(IMG), .BIT_LENGTH(5)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .out_pix0(out_pix0), .out_pix1(out_pix1), .out_pix2(out_pix2),
        .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready),
        .load_end(load_end), .busy(busy), .frame_done(frame_done)
    );

    pixel_stream_packer #(.IMG_DIM(3), .BIT_LENGTH(5)) dut3 (
        .clk(clk), .reset(reset), .start(s3_start),
        .in_pixel(s3_pixel), .in_valid(s3_valid), .in_ready(s3_in_ready),
        .out_pix0(s3_p0), .out_pix1(s3_p1), .out_pix2(s3_p2),
        .out_count(s3_count), .out_valid(s3_out_valid), .out_ready(s3_out_ready),
        .load_end(s3_load_end), .busy(s3_busy), .frame_done(s3_frame_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    beat_t      exp_q[$];
    logic [4:0] grp[$];
    int         acc_cnt = 0;
    int         beat_cnt = 0;
    int         fd_cnt = 0;
    int         fd_target = 0;
    bit         fd_expect = 0;
    bit         prev_stall = 0;
    beat_t      snap;
    beat_t      beat_log[0:199];

    // Scoreboard: expected beats come from the pixels the bench saw accepted.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = {out_pix0, out_pix1, out_pix2, out_count, load_end};
        if (!reset) begin
            grp.delete();
            exp_q.delete();
            acc_cnt    = 0;
            fd_expect  = 0;
            prev_stall = 0;
        end else begin
            if (start && !busy) begin
                grp.delete();
                acc_cnt = 0;
            end
            if (fd_expect) begin
                chk("frame_done_pulse", 32'(frame_done), 1);
                if (frame_done) fd_cnt++;
                fd_expect = 0;
            end else if (frame_done) begin
                chk("frame_done_spurious", 32'(frame_done), 0);
            end
            if (in_valid && in_ready) begin
                grp.push_back(in_pixel);
                acc_cnt++;
                if (grp.size() == 3 || acc_cnt == TOTAL) begin
                    e.p0  = grp[0];
                    e.p1  = (grp.size() > 1) ? grp[1] : 5'd0;
                    e.p2  = (grp.size() > 2) ? grp[2] : 5'd0;
                    e.cnt = 2'(grp.size());
                    e.le  = (acc_cnt == TOTAL);
                    exp_q.push_back(e);
                    grp.delete();
                end
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_hold", 32'(cur), 32'(snap));
            end
            if (out_valid) chk("in_ready_in_send", 32'(in_ready), 0);
            prev_stall = out_valid && !out_ready;
            if (prev_stall) snap = cur;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_p0", 32'(cur.p0), 32'(e.p0));
                    chk("beat_p1", 32'(cur.p1), 32'(e.p1));
                    chk("beat_p2", 32'(cur.p2), 32'(e.p2));
                    chk("beat_count", 32'(cur.cnt), 32'(e.cnt));
                    chk("beat_load_end", 32'(cur.le), 32'(e.le));
                end
                if (beat_cnt < 200) beat_log[beat_cnt] = cur;
                beat_cnt++;
                if (load_end) fd_expect = 1;
            end
        end
    end

    beat_t log3[0:3];
    int    nb3 = 0;
    int    fd3 = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (s3_out_valid) begin
                if (nb3 < 4) log3[nb3] = {s3_p0, s3_p1, s3_p2, s3_count, s3_load_end};
                nb3++;
            end
            if (s3_frame_done) fd3++;
        end
    end

    function automatic logic [4:0] pix_val(input int idx, input bit toggle);
        return toggle ? 5'((idx * 7 + 3) % 32) : 5'(idx % 32);
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_source(input int n, input int abort_at, input bit toggle);
        int idx = 0;
        int cyc = 0;
        int pat_i = 0;
        bit acc;
        bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        while (idx < n && idx != abort_at && cyc < 5000) begin
            in_valid = toggle ? pat[pat_i % 6] : 1'b1;
            in_pixel = in_valid ? pix_val(idx, toggle) : ~pix_val(idx, toggle);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (in_ready) pat_i++;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 5000) chk("source_timeout", 32'(idx), 32'(n));
    endtask

    task automatic stall_proc();
        for (int i = 0; i < 2000 && !out_valid; i++) @(negedge clk);
        chk("stall_reached", 32'(out_valid), 1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;
    endtask

    task automatic mid_start_proc();
        for (int i = 0; i < 2000 && beat_cnt < 10; i++) @(posedge clk);
        chk("mid_start_reached", 32'(beat_cnt >= 10), 1);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_frame_done();
        fd_target++;
        for (int i = 0; i < 100 && fd_cnt < fd_target; i++) @(posedge clk);
        chk("frame_done_seen", 32'(fd_cnt), 32'(fd_target));
    endtask

    vec_t tbl[6];

    task automatic check_table();
        for (int i = 0; i < 6; i++) begin
            beat_t b;
            b = beat_log[tbl[i].beat];
            chk("tbl_p0", 32'(b.p0), 32'(tbl[i].p0));
            chk("tbl_p1", 32'(b.p1), 32'(tbl[i].p1));
            chk("tbl_p2", 32'(b.p2), 32'(tbl[i].p2));
            chk("tbl_count", 32'(b.cnt), 32'(tbl[i].cnt));
            chk("tbl_load_end", 32'(b.le), 32'(tbl[i].le));
        end
    endtask

    task automatic run_frame(input int abort_at, input bit toggle, input bit stall, input bit mid_start);
        beat_cnt  = 0;
        out_ready = !stall;
        pulse_start();
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 1);
        @(posedge clk); #1;
        fork
            run_source(TOTAL, abort_at, toggle);
            begin if (stall) stall_proc(); end
            begin if (mid_start) mid_start_proc(); end
        join
        if (abort_at < 0) begin
            wait_frame_done();
            chk("beats_per_frame", 32'(beat_cnt), 32'(NBEATS));
            chk("sb_drained", 32'(exp_q.size()), 0);
            @(negedge clk);
            chk("busy_after_frame", 32'(busy), 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_pix"}, 32'({out_pix0, out_pix1, out_pix2}), 0);
        chk({tag, "_count"}, 32'(out_count), 0);
        chk({tag, "_load_end"}, 32'(load_end), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic run_dut3();
        int acc3 = 0;
        @(posedge clk); #1 s3_start = 1'b1;
        @(posedge clk); #1 s3_start = 1'b0;
        s3_valid = 1'b1;
        for (int c = 0; c < 200 && acc3 < 9; c++) begin
            s3_pixel = 5'(10 + acc3);
            @(negedge clk);
            if (s3_in_ready) acc3++;
            @(posedge clk); #1;
        end
        s3_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("d3_beats", 32'(nb3), 3);
        chk("d3_frame_done", 32'(fd3), 1);
        for (int b = 0; b < 3; b++) begin
            chk("d3_p0", 32'(log3[b].p0), 32'(10 + 3 * b));
            chk("d3_p1", 32'(log3[b].p1), 32'(11 + 3 * b));
            chk("d3_p2", 32'(log3[b].p2), 32'(12 + 3 * b));
            chk("d3_count", 32'(log3[b].cnt), 3);
            chk("d3_load_end", 32'(log3[b].le), 32'(b == 2));
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{beat: 0,   p0: 0,  p1: 1,  p2: 2,  cnt: 3, le: 0};
        tbl[1] = '{beat: 1,   p0: 3,  p1: 4,  p2: 5,  cnt: 3, le: 0};
        tbl[2] = '{beat: 10,  p0: 30, p1: 31, p2: 0,  cnt: 3, le: 0};
        tbl[3] = '{beat: 11,  p0: 1,  p1: 2,  p2: 3,  cnt: 3, le: 0};
        tbl[4] = '{beat: 132, p0: 12, p1: 13, p2: 14, cnt: 3, le: 0};
        tbl[5] = '{beat: 133, p0: 15, p1: 0,  p2: 0,  cnt: 1, le: 1};

        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
        s3_start = 1'b0; s3_valid = 1'b0; s3_pixel = '0; s3_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 reset = 1'b1;

        // in_valid in IDLE must not be taken
        in_valid = 1'b1; in_pixel = 5'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 0);
        chk("idle_busy", 32'(busy), 0);
        @(posedge clk); #1 in_valid = 1'b0;

        run_dut3();

        run_frame(-1, 1'b0, 1'b0, 1'b0);
        check_table();

        run_frame(-1, 1'b0, 1'b1, 1'b1);
        check_table();

        run_frame(-1, 1'b1, 1'b0, 1'b0);

        // Abort at pixel 50 with reset, then a clean frame
        run_frame(50, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_all_zero("post_abort");
        chk("no_fd_after_abort", 32'(fd_cnt), 32'(fd_target));
        @(posedge clk); #1 in_valid = 1'b0;

        run_frame(-1, 1'b0, 1'b0, 1'b0);
        check_table();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
